// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and byte width for the SPI master
package spi_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [2:0] {IDLE, SHIFT, WAIT, HOLD, GAP} spi_state_t;
endpackage

// File: rtl/spi_master_if.sv
// spi_master_if: byte stream handshake plus SPI pins of the SPI master
interface spi_master_if;
  import spi_pkg::*;
  logic              byte_vld_in;
  logic [BYTE_W-1:0] byte_data_in;
  logic              byte_last_in;
  logic              byte_rdy_out;
  logic              busy_out;
  logic              frame_done_out;
  logic              spi_sclk_out;
  logic              spi_mosi_out;
  logic              spi_cs_n_out;
  modport master (
    output byte_vld_in, byte_data_in, byte_last_in,
    input  byte_rdy_out, busy_out, frame_done_out, spi_sclk_out, spi_mosi_out, spi_cs_n_out
  );
  modport slave (
    input  byte_vld_in, byte_data_in, byte_last_in,
    output byte_rdy_out, busy_out, frame_done_out, spi_sclk_out, spi_mosi_out, spi_cs_n_out
  );
endinterface

// File: rtl/spi_master.sv
// spi_master: mode-0 MSB-first SPI transmitter framing a valid/ready byte stream with CS_n
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input logic        clk_in,
  input logic        spi_rst_n,
  spi_master_if.slave bus
);
  localparam int HW = $clog2(CLK_DIV);
  localparam logic [HW-1:0] HMAX = HW'(CLK_DIV - 1);
  if (CLK_DIV < 2) begin : g_div_chk
    $error("spi_master: CLK_DIV must be at least 2");
  end
  spi_state_t        state_q, state_d;
  logic [HW-1:0]     half_q, half_d;
  logic [3:0]        phase_q, phase_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic              last_q, last_d;
  logic              sclk_q, sclk_d;
  logic              cs_n_q, cs_n_d;
  logic              done_q, done_d;
  logic              rdy, hs, half_end, last_phase;
  assign rdy        = (state_q == IDLE) || (state_q == WAIT);
  assign hs         = rdy && bus.byte_vld_in;
  assign half_end   = half_q == HMAX;
  assign last_phase = phase_q == 4'd15;
  always_ff @(posedge clk_in or negedge spi_rst_n) begin
    if (!spi_rst_n) begin
      state_q <= IDLE;
      half_q  <= '0;
      phase_q <= '0;
      shift_q <= '0;
      last_q  <= 1'b0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      phase_q <= phase_d;
      shift_q <= shift_d;
      last_q  <= last_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      done_q  <= done_d;
    end
  end
  // MOSI is the shift register MSB: the final bit is not shifted out so WAIT holds it, GAP clears it
  always_comb begin
    state_d = state_q;
    half_d  = (state_q inside {SHIFT, HOLD, GAP}) && !half_end ? half_q + 1'b1 : '0;
    phase_d = phase_q;
    shift_d = shift_q;
    last_d  = last_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    done_d  = 1'b0;
    if (hs) begin
      state_d = SHIFT;
      shift_d = bus.byte_data_in;
      last_d  = bus.byte_last_in;
      cs_n_d  = 1'b0;
    end else if (half_end) begin
      case (state_q)
        SHIFT: begin
          phase_d = phase_q + 4'd1;
          sclk_d  = !last_phase && !sclk_q;
          shift_d = (phase_q[0] && !last_phase) ? {shift_q[BYTE_W-2:0], 1'b0} : shift_q;
          state_d = !last_phase ? SHIFT : last_q ? HOLD : WAIT;
        end
        HOLD: begin
          state_d = GAP;
          cs_n_d  = 1'b1;
          shift_d = '0;
        end
        GAP: begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
        default: ;
      endcase
    end
  end
  assign bus.byte_rdy_out   = rdy;
  assign bus.busy_out       = state_q != IDLE;
  assign bus.frame_done_out = done_q;
  assign bus.spi_sclk_out   = sclk_q;
  assign bus.spi_mosi_out   = shift_q[BYTE_W-1];
  assign bus.spi_cs_n_out   = cs_n_q;
endmodule
